// File: rtl/rom_load_ctrl.sv
// ROM download controller: takes the HPS byte stream, routes each byte to one
// of four ROM regions, keeps the game core in reset while loading and for a
// settle window afterwards, and reports byte count, checksum and address errors.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, no image loaded yet, core held in reset
// LOAD   | download active, strobes written into the ROM regions
// SETTLE | core held in reset while the settle counter runs down
// RUN    | core released
module rom_load_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter logic [16:0] MAX_ADDR      = 17'h030FF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [16:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        rst_req,
  output logic        prog_we,
  output logic        char_we,
  output logic        mot_we,
  output logic        sync_we,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset_n,
  output logic        load_done,
  output logic [16:0] byte_cnt,
  output logic [7:0]  checksum,
  output logic        addr_err
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  // End of a download: the entry cycle itself is the first of SETTLE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_END_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  // Reset request: a full SETTLE_CYCLES window follows the last requested cycle.
  localparam logic [CNT_W-1:0] CNT_RST_REQ  = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             wr_prev;

  logic             wr_rise;
  logic             addr_ok;
  logic             hit_prog;
  logic             hit_char;
  logic             hit_mot;
  logic             hit_sync;
  logic [12:0]      local_addr;

  assign wr_rise = (state == LOAD) && dn_wr && !wr_prev;
  assign addr_ok = (dn_addr <= MAX_ADDR);

  // Region decode and base subtraction for the current download address.
  always_comb begin
    hit_prog   = 1'b0;
    hit_char   = 1'b0;
    hit_mot    = 1'b0;
    hit_sync   = 1'b0;
    local_addr = 13'd0;
    if (dn_addr <= 17'h01FFF) begin
      hit_prog   = 1'b1;
      local_addr = dn_addr[12:0];
    end else if (dn_addr <= 17'h027FF) begin
      hit_char   = 1'b1;
      local_addr = 13'(dn_addr - 17'h02000);
    end else if (dn_addr <= 17'h02FFF) begin
      hit_mot    = 1'b1;
      local_addr = 13'(dn_addr - 17'h02800);
    end else if (dn_addr <= 17'h030FF) begin
      hit_sync   = 1'b1;
      local_addr = 13'(dn_addr - 17'h03000);
    end
  end

  // Sequencer, write path, statistics and edge detector in one registered block.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      wr_prev      <= 1'b0;
      prog_we      <= 1'b0;
      char_we      <= 1'b0;
      mot_we       <= 1'b0;
      sync_we      <= 1'b0;
      rom_addr     <= 13'd0;
      rom_data     <= 8'd0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      byte_cnt     <= 17'd0;
      checksum     <= 8'd0;
      addr_err     <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      char_we <= 1'b0;
      mot_we  <= 1'b0;
      sync_we <= 1'b0;

      // Edge history only advances while loading, so a strobe already high
      // when a download starts still counts as a fresh write.
      if (state == LOAD) begin
        wr_prev <= dn_wr;
      end

      case (state)
        IDLE: begin
          core_reset_n <= 1'b0;
          if (dn_download) begin
            state    <= LOAD;
            byte_cnt <= 17'd0;
            checksum <= 8'd0;
            addr_err <= 1'b0;
          end
        end

        LOAD: begin
          core_reset_n <= 1'b0;
          if (wr_rise) begin
            if (addr_ok) begin
              prog_we  <= hit_prog;
              char_we  <= hit_char;
              mot_we   <= hit_mot;
              sync_we  <= hit_sync;
              rom_addr <= local_addr;
              rom_data <= dn_data;
              checksum <= checksum + dn_data;
              if (byte_cnt != 17'h1FFFF) begin
                byte_cnt <= byte_cnt + 17'd1;
              end
            end else begin
              addr_err <= 1'b1;
            end
          end
          if (!dn_download) begin
            state      <= SETTLE;
            load_done  <= 1'b1;
            settle_cnt <= CNT_END_LOAD;
          end
        end

        SETTLE: begin
          core_reset_n <= 1'b0;
          if (dn_download) begin
            state    <= LOAD;
            byte_cnt <= 17'd0;
            checksum <= 8'd0;
            addr_err <= 1'b0;
          end else if (rst_req) begin
            settle_cnt <= CNT_RST_REQ;
          end else if (settle_cnt == '0) begin
            state        <= RUN;
            core_reset_n <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        RUN: begin
          if (dn_download) begin
            state        <= LOAD;
            core_reset_n <= 1'b0;
            byte_cnt     <= 17'd0;
            checksum     <= 8'd0;
            addr_err     <= 1'b0;
          end else if (rst_req) begin
            state        <= SETTLE;
            core_reset_n <= 1'b0;
            settle_cnt   <= CNT_RST_REQ;
          end
        end

        default: begin
          state        <= IDLE;
          core_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: stimulus pushes expected ROM writes,
// a negedge monitor pops and compares every *_we it sees.
module tb_rom_load_ctrl;

  localparam int SETTLE = 8;

  logic        CLK;
  logic        RESET;
  logic        dn_download;
  logic        dn_wr;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        rst_req;
  logic        prog_we, char_we, mot_we, sync_we;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset_n;
  logic        load_done;
  logic [16:0] byte_cnt;
  logic [7:0]  checksum;
  logic        addr_err;

  rom_load_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RESET(RESET), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .rst_req(rst_req),
    .prog_we(prog_we), .char_we(char_we), .mot_we(mot_we), .sync_we(sync_we),
    .rom_addr(rom_addr), .rom_data(rom_data), .core_reset_n(core_reset_n),
    .load_done(load_done), .byte_cnt(byte_cnt), .checksum(checksum),
    .addr_err(addr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int region;
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference view of the current download.
  int m_cnt = 0;
  int m_sum = 0;
  int m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void decode(input int a, output int r, output int l);
    if (a < 'h2000)      begin r = 0; l = a;          end
    else if (a < 'h2800) begin r = 1; l = a - 'h2000; end
    else if (a < 'h3000) begin r = 2; l = a - 'h2800; end
    else                 begin r = 3; l = a - 'h3000; end
  endfunction

  // Monitor: every write enable must match the oldest expected write.
  always @(negedge CLK) begin : mon
    int   nwe;
    int   rg;
    exp_t e;
    if (!RESET) begin
      nwe = int'(prog_we) + int'(char_we) + int'(mot_we) + int'(sync_we);
      rg  = prog_we ? 0 : char_we ? 1 : mot_we ? 2 : 3;
      if (nwe > 1) begin
        n_cmp++; n_bad++;
        $display("FAIL we_onehot: got %0d enables expected 1", nwe);
      end
      if (nwe >= 1) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_we: got region %0d addr %0h data %0h expected none", rg, rom_addr, rom_data);
        end else begin
          e = sbq.pop_front();
          if (rg != e.region || int'(rom_addr) != e.addr || int'(rom_data) != e.data || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL rom_write: got region %0d addr %0h data %0h cyc %0d expected region %0d addr %0h data %0h cyc %0d",
                     rg, rom_addr, rom_data, cyc, e.region, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, {28'd0, prog_we, char_we, mot_we, sync_we}, 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rom_data"}, 32'(rom_data), 32'd0);
    chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dl();
    step();
    dn_download = 1'b1;
    m_cnt = 0; m_sum = 0; m_err = 0;
    step();
  endtask

  // One strobe: dn_wr high for hold edges, then low for gap edges.
  task automatic wr(input int a, input int d, input int hold, input int gap, input bit in_load);
    int r, l;
    exp_t e;
    dn_addr = 17'(a);
    dn_data = 8'(d);
    dn_wr   = 1'b1;
    if (in_load) begin
      if (a <= 'h30FF) begin
        decode(a, r, l);
        e.region = r; e.addr = l; e.data = d; e.cyc = cyc + 1;
        sbq.push_back(e);
        m_cnt++;
        m_sum = (m_sum + d) % 256;
      end else begin
        m_err = 1;
      end
    end
    repeat (hold) step();
    dn_wr = 1'b0;
    repeat (gap) step();
  endtask

  task automatic end_dl(input string tag);
    int low;
    bit up;
    dn_download = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    chk({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
    chk({tag, "_addr_err"}, 32'(addr_err), 32'(m_err));
    low = core_reset_n ? 0 : 1;
    up  = 1'b0;
    for (int i = 0; i < 4000 && !up; i++) begin
      @(negedge CLK);
      if (core_reset_n) up = 1'b1;
      else low++;
    end
    chk({tag, "_settle_len"}, 32'(low), 32'(SETTLE));
  endtask

  task automatic rst_pulse(input int len, input string tag);
    int low;
    bit up;
    step();
    rst_req = 1'b1;
    low = 0;
    up  = 1'b0;
    for (int i = 0; i < 4000 && !up; i++) begin
      @(negedge CLK);
      if (core_reset_n && low > 0) up = 1'b1;
      else if (!core_reset_n) low++;
      if (low >= len) rst_req = 1'b0;
    end
    rst_req = 1'b0;
    chk({tag, "_rst_low_len"}, 32'(low), 32'(len + SETTLE));
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, d, h, g;
    exp_t e;
    RESET = 1'b1; dn_download = 1'b0; dn_wr = 1'b0;
    dn_addr = '0; dn_data = '0; rst_req = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("por");
    step();
    RESET = 1'b0;

    // Directed four-region download.
    start_dl();
    wr('h00000, 'h11, 1, 1, 1);
    wr('h02001, 'h22, 1, 2, 1);
    wr('h02805, 'h33, 2, 1, 1);
    wr('h030FF, 'h44, 1, 1, 1);
    chk("four_region_cnt_model", 32'(m_cnt), 32'd4);
    end_dl("four");
    chk("four_checksum_abs", 32'(checksum), 32'hAA);

    // Reset request in RUN.
    rst_pulse(3, "rr3");

    // Held strobe and an out-of-range write in one download.
    start_dl();
    wr('h00010, 'h5A, 5, 2, 1);
    wr('h03100, 'h55, 1, 3, 1);
    end_dl("held_err");
    chk("held_err_cnt_abs", 32'(byte_cnt), 32'd1);
    chk("held_err_flag_abs", 32'(addr_err), 32'd1);

    // Strobes in RUN are ignored.
    step();
    wr('h00020, 'h77, 1, 2, 0);
    wr('h02100, 'h88, 3, 2, 0);
    @(negedge CLK);
    chk("run_wr_byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    chk("run_wr_checksum", 32'(checksum), 32'(m_sum));

    // Randomised downloads, reset requests and stray strobes.
    for (int k = 0; k < 6; k++) begin
      start_dl();
      n = $urandom_range(5, 12);
      for (int j = 0; j < n; j++) begin
        a = $urandom_range(0, 'h3140);
        d = $urandom_range(0, 255);
        h = $urandom_range(1, 4);
        g = $urandom_range(1, 3);
        wr(a, d, h, g, 1);
      end
      end_dl($sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) rst_pulse($urandom_range(1, 4), $sformatf("rnd_rr%0d", k));
      step();
      wr($urandom_range(0, 'h30FF), $urandom_range(0, 255), 1, 1, 0);
    end

    // Reset in the middle of a load.
    start_dl();
    wr('h00100, 'h12, 1, 1, 1);
    wr('h02200, 'h34, 1, 2, 1);
    step();
    RESET = 1'b1;
    dn_download = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("midload");
    step();
    RESET = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    chk("midload_idle_load_done", 32'(load_done), 32'd0);
    chk("midload_idle_core_reset_n", 32'(core_reset_n), 32'd0);
    start_dl();
    wr('h02A00, 'h9C, 1, 1, 1);
    end_dl("fresh");
    chk("fresh_cnt_abs", 32'(byte_cnt), 32'd1);

    // Strobe already high when RESET releases: first LOAD cycle takes it.
    step();
    RESET = 1'b1;
    step();
    dn_download = 1'b1;
    dn_wr = 1'b1;
    dn_addr = 17'h02010;
    dn_data = 8'hE7;
    m_cnt = 1; m_sum = 'hE7; m_err = 0;
    RESET = 1'b0;
    e.region = 1; e.addr = 'h10; e.data = 'hE7; e.cyc = cyc + 2;
    sbq.push_back(e);
    repeat (3) step();
    dn_wr = 1'b0;
    repeat (2) step();
    end_dl("rel_edge");

    repeat (4) step();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
